// File: rtl/local_history_table_pkg.sv
// Shared types and defaults for the local history table and the local
// predictor that consumes its history as a counter index.
package lht_pkg;

   localparam int LHT_ENTRIES = 1024;
   localparam int LHT_HIST_W  = 10;
   localparam int LHT_IDX_LSB = 2;
   localparam int LHT_IDX_W   = $clog2(LHT_ENTRIES);

   typedef logic [LHT_IDX_W-1:0]  lht_idx_t;
   typedef logic [LHT_HIST_W-1:0] lht_hist_t;

   typedef enum logic {
      LHT_INIT = 1'b0,
      LHT_RUN  = 1'b1
   } lht_state_e;

   // Branch PC to table index; bits above and below the index field are ignored.
   function automatic lht_idx_t pc_to_idx(input logic [31:0] pc);
      return pc[LHT_IDX_LSB +: LHT_IDX_W];
   endfunction

endpackage

// File: rtl/local_history_table_if.sv
// Lookup/update bus between the fetch-side predictor logic (master) and the
// local history table (slave).
interface local_history_table_if
   import lht_pkg::*;
#(
   parameter int HIST_W = LHT_HIST_W
);

   logic              lookup_valid;
   logic [31:0]       lookup_pc;
   logic              lookup_ready;
   logic              hist_valid;
   logic [HIST_W-1:0] hist_out;
   logic              update_valid;
   logic [31:0]       update_pc;
   logic              update_taken;
   logic              busy;

   modport master (
      output lookup_valid, lookup_pc, update_valid, update_pc, update_taken,
      input  lookup_ready, hist_valid, hist_out, busy
   );

   modport slave (
      input  lookup_valid, lookup_pc, update_valid, update_pc, update_taken,
      output lookup_ready, hist_valid, hist_out, busy
   );

endinterface

// File: rtl/local_history_table_storage.sv
// History array: one write port that either clears an entry or shifts a
// resolved outcome into it, plus one registered read port. A read of the
// entry being written in the same cycle returns the freshly written value.
module lht_storage #(
   parameter int ENTRIES = 1024,
   parameter int HIST_W  = 10,
   parameter int IDX_W   = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_wrEn,
   input  logic [IDX_W-1:0]  i_wrIdx,
   input  logic              i_wrClear,
   input  logic              i_wrBit,
   input  logic              i_rdEn,
   input  logic [IDX_W-1:0]  i_rdIdx,
   output logic [HIST_W-1:0] o_rdData
);

   logic [HIST_W-1:0] r_mem [ENTRIES];
   logic [HIST_W-1:0] r_rdData;
   logic [HIST_W-1:0] w_wrData;

   // New value for the written entry: zero during the sweep, else old history shifted left with the outcome in bit 0.
   always_comb begin
      w_wrData = '0;
      if (!i_wrClear) begin
         w_wrData = {r_mem[i_wrIdx][HIST_W-2:0], i_wrBit};
      end
   end

   // Array write; contents are not reset because the init sweep clears them.
   always_ff @(posedge clock) begin
      if (i_wrEn) begin
         r_mem[i_wrIdx] <= w_wrData;
      end
   end

   // Registered read with same-index bypass; holds its value when no read is issued.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rdData <= '0;
      end else if (i_rdEn) begin
         if (i_wrEn && (i_wrIdx == i_rdIdx)) begin
            r_rdData <= w_wrData;
         end else begin
            r_rdData <= r_mem[i_rdIdx];
         end
      end
   end

   assign o_rdData = r_rdData;

endmodule

// File: rtl/local_history_table.sv
// Local history table: sweeps its array to zero after reset, then serves
// one-cycle registered history lookups and shifts in retired outcomes.
module local_history_table
   import lht_pkg::*;
#(
   parameter int ENTRIES = LHT_ENTRIES,
   parameter int HIST_W  = LHT_HIST_W,
   parameter int IDX_LSB = LHT_IDX_LSB
) (
   input  logic                 clock,
   input  logic                 reset,
   local_history_table_if.slave bus
);

   localparam int IDX_W = $clog2(ENTRIES);

   lht_state_e       r_state;
   lht_state_e       w_nextState;
   logic [IDX_W-1:0] r_initPtr;
   logic [IDX_W-1:0] w_nextPtr;
   logic             r_histValid;

   logic             w_wrEn;
   logic [IDX_W-1:0] w_wrIdx;
   logic             w_wrClear;
   logic             w_wrBit;
   logic             w_rdEn;
   logic [IDX_W-1:0] w_rdIdx;
   logic [HIST_W-1:0] w_rdData;

   // State and sweep pointer registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= LHT_INIT;
         r_initPtr <= '0;
      end else begin
         r_state   <= w_nextState;
         r_initPtr <= w_nextPtr;
      end
   end

   // Sweep sequencing during INIT; in RUN, route accepted lookups and updates to the array.
   always_comb begin
      w_nextState = r_state;
      w_nextPtr   = r_initPtr;
      w_wrEn      = 1'b0;
      w_wrIdx     = r_initPtr;
      w_wrClear   = 1'b1;
      w_wrBit     = 1'b0;
      w_rdEn      = 1'b0;
      w_rdIdx     = bus.lookup_pc[IDX_LSB +: IDX_W];
      if (!reset) begin
         case (r_state)
            LHT_INIT: begin
               w_wrEn    = 1'b1;
               w_nextPtr = r_initPtr + IDX_W'(1);
               if (r_initPtr == IDX_W'(ENTRIES - 1)) begin
                  w_nextState = LHT_RUN;
               end
            end
            LHT_RUN: begin
               w_rdEn    = bus.lookup_valid;
               w_wrEn    = bus.update_valid;
               w_wrIdx   = bus.update_pc[IDX_LSB +: IDX_W];
               w_wrClear = 1'b0;
               w_wrBit   = bus.update_taken;
            end
            default: begin
               w_nextState = LHT_INIT;
            end
         endcase
      end
   end

   // One-cycle valid pulse for each accepted lookup; dropped on reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_histValid <= 1'b0;
      end else begin
         r_histValid <= w_rdEn;
      end
   end

   lht_storage #(
      .ENTRIES (ENTRIES),
      .HIST_W  (HIST_W),
      .IDX_W   (IDX_W)
   ) u_storage (
      .clock     (clock),
      .reset     (reset),
      .i_wrEn    (w_wrEn),
      .i_wrIdx   (w_wrIdx),
      .i_wrClear (w_wrClear),
      .i_wrBit   (w_wrBit),
      .i_rdEn    (w_rdEn),
      .i_rdIdx   (w_rdIdx),
      .o_rdData  (w_rdData)
   );

   assign bus.lookup_ready = (r_state == LHT_RUN);
   assign bus.busy         = (r_state != LHT_RUN);
   assign bus.hist_valid   = r_histValid;
   assign bus.hist_out     = w_rdData;

endmodule

// File: tb/tb_local_history_table.sv
// Directed testbench for local_history_table: reset, init sweep, shifting,
// bypass, aliasing, shift-out and reset during operation.
module tb_local_history_table;

   logic clock;
   logic reset;
   int   compared;
   int   mismatched;

   local_history_table_if bus ();

   local_history_table dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Present one cycle of inputs, clock it, and return 1 time unit after the edge.
   task automatic drive(input logic lv, input logic [31:0] lpc,
                        input logic uv, input logic [31:0] upc, input logic ut);
      bus.lookup_valid = lv;
      bus.lookup_pc    = lpc;
      bus.update_valid = uv;
      bus.update_pc    = upc;
      bus.update_taken = ut;
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) idle();
      compared++;
      if (bus.lookup_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL rst_ready: got %b expected 0", bus.lookup_ready);
      end
      compared++;
      if (bus.busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL rst_busy: got %b expected 1", bus.busy);
      end
      compared++;
      if (bus.hist_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL rst_hist_valid: got %b expected 0", bus.hist_valid);
      end
      compared++;
      if (bus.hist_out !== 10'h000) begin
         mismatched++;
         $display("[TB] FAIL rst_hist_out: got %h expected 000", bus.hist_out);
      end
   endtask

   // Releases reset and walks the 1024-cycle sweep while hammering idx 5 with lookups and updates.
   task automatic test_init_sweep(input string tag);
      int badReady;
      int badValid;
      badReady = 0;
      badValid = 0;
      reset = 1'b0;
      if (bus.lookup_ready !== 1'b0 || bus.busy !== 1'b1) badReady++;
      for (int c = 1; c <= 1023; c++) begin
         drive(1'b1, 32'h0000_0014, 1'b1, 32'h0000_0014, 1'b1);
         if (bus.lookup_ready !== 1'b0 || bus.busy !== 1'b1) badReady++;
         if (bus.hist_valid !== 1'b0) badValid++;
      end
      compared++;
      if (badReady !== 0) begin
         mismatched++;
         $display("[TB] FAIL %s_early_ready: got %0d bad cycles expected 0", tag, badReady);
      end
      drive(1'b1, 32'h0000_0014, 1'b1, 32'h0000_0014, 1'b1);
      if (bus.hist_valid !== 1'b0) badValid++;
      compared++;
      if (badValid !== 0) begin
         mismatched++;
         $display("[TB] FAIL %s_init_hist_valid: got %0d pulses expected 0", tag, badValid);
      end
      compared++;
      if (bus.lookup_ready !== 1'b1 || bus.busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL %s_ready_1025: got ready=%b busy=%b expected ready=1 busy=0",
                  tag, bus.lookup_ready, bus.busy);
      end
      idle();
   endtask

   task automatic test_first_lookup();
      drive(1'b1, 32'h0000_0FFC, 1'b0, 32'h0, 1'b0);
      compared++;
      if (bus.hist_valid !== 1'b1 || bus.hist_out !== 10'h000) begin
         mismatched++;
         $display("[TB] FAIL first_lookup: got v=%b h=%h expected v=1 h=000", bus.hist_valid, bus.hist_out);
      end
      idle();
      compared++;
      if (bus.hist_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL first_valid_pulse: got %b expected 0", bus.hist_valid);
      end
   endtask

   task automatic test_update_shift();
      drive(1'b0, 32'h0, 1'b1, 32'h0000_1004, 1'b1);
      drive(1'b0, 32'h0, 1'b1, 32'h0000_1004, 1'b0);
      drive(1'b0, 32'h0, 1'b1, 32'h0000_1004, 1'b1);
      drive(1'b1, 32'h0000_1004, 1'b0, 32'h0, 1'b0);
      compared++;
      if (bus.hist_valid !== 1'b1 || bus.hist_out !== 10'h005) begin
         mismatched++;
         $display("[TB] FAIL upd_lookup: got v=%b h=%h expected v=1 h=005", bus.hist_valid, bus.hist_out);
      end
      idle();
      compared++;
      if (bus.hist_valid !== 1'b0 || bus.hist_out !== 10'h005) begin
         mismatched++;
         $display("[TB] FAIL upd_hold: got v=%b h=%h expected v=0 h=005", bus.hist_valid, bus.hist_out);
      end
   endtask

   task automatic test_bypass();
      drive(1'b1, 32'h0000_1004, 1'b1, 32'h0000_1004, 1'b1);
      compared++;
      if (bus.hist_valid !== 1'b1 || bus.hist_out !== 10'h00B) begin
         mismatched++;
         $display("[TB] FAIL bypass: got v=%b h=%h expected v=1 h=00b", bus.hist_valid, bus.hist_out);
      end
      drive(1'b1, 32'h0000_1004, 1'b0, 32'h0, 1'b0);
      compared++;
      if (bus.hist_valid !== 1'b1 || bus.hist_out !== 10'h00B) begin
         mismatched++;
         $display("[TB] FAIL bypass_after: got v=%b h=%h expected v=1 h=00b", bus.hist_valid, bus.hist_out);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 32'h0000_1004, 1'b1, 32'h0000_000C, 1'b1);
      compared++;
      if (bus.hist_valid !== 1'b1 || bus.hist_out !== 10'h00B) begin
         mismatched++;
         $display("[TB] FAIL b2b_diff_idx: got v=%b h=%h expected v=1 h=00b", bus.hist_valid, bus.hist_out);
      end
      drive(1'b1, 32'hF000_300C, 1'b0, 32'h0, 1'b0);
      compared++;
      if (bus.hist_valid !== 1'b1 || bus.hist_out !== 10'h001) begin
         mismatched++;
         $display("[TB] FAIL b2b_idx3: got v=%b h=%h expected v=1 h=001", bus.hist_valid, bus.hist_out);
      end
      drive(1'b1, 32'h0000_0FFC, 1'b0, 32'h0, 1'b0);
      compared++;
      if (bus.hist_valid !== 1'b1 || bus.hist_out !== 10'h000) begin
         mismatched++;
         $display("[TB] FAIL b2b_idx1023: got v=%b h=%h expected v=1 h=000", bus.hist_valid, bus.hist_out);
      end
      idle();
   endtask

   task automatic test_shift_out();
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, 32'h0, 1'b1, (i % 2 == 0) ? 32'h0000_001C : 32'hFFFF_F01F, 1'b1);
      end
      drive(1'b1, 32'h0000_001C, 1'b0, 32'h0, 1'b0);
      compared++;
      if (bus.hist_out !== 10'h3FF) begin
         mismatched++;
         $display("[TB] FAIL shift_sat: got %h expected 3ff", bus.hist_out);
      end
      drive(1'b0, 32'h0, 1'b1, 32'h0000_001C, 1'b0);
      drive(1'b1, 32'h0000_001C, 1'b0, 32'h0, 1'b0);
      compared++;
      if (bus.hist_out !== 10'h3FE) begin
         mismatched++;
         $display("[TB] FAIL shift_one_nt: got %h expected 3fe", bus.hist_out);
      end
      for (int i = 0; i < 9; i++) begin
         drive(1'b0, 32'h0, 1'b1, 32'h8000_001C, 1'b0);
      end
      drive(1'b1, 32'h0000_001C, 1'b0, 32'h0, 1'b0);
      compared++;
      if (bus.hist_out !== 10'h000) begin
         mismatched++;
         $display("[TB] FAIL shift_out: got %h expected 000", bus.hist_out);
      end
      idle();
   endtask

   task automatic test_reset_mid_run();
      logic [9:0] pattern;
      pattern = 10'h2AA;
      for (int b = 9; b >= 0; b--) begin
         drive(1'b0, 32'h0, 1'b1, 32'h0000_0014, pattern[b]);
      end
      drive(1'b1, 32'h0000_0014, 1'b0, 32'h0, 1'b0);
      compared++;
      if (bus.hist_out !== 10'h2AA) begin
         mismatched++;
         $display("[TB] FAIL mid_build: got %h expected 2aa", bus.hist_out);
      end
      reset = 1'b1;
      drive(1'b1, 32'h0000_0014, 1'b0, 32'h0, 1'b0);
      compared++;
      if (bus.hist_valid !== 1'b0 || bus.hist_out !== 10'h000 || bus.lookup_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL mid_reset: got v=%b h=%h r=%b expected v=0 h=000 r=0",
                  bus.hist_valid, bus.hist_out, bus.lookup_ready);
      end
      test_init_sweep("mid");
      drive(1'b1, 32'h0000_0014, 1'b0, 32'h0, 1'b0);
      compared++;
      if (bus.hist_valid !== 1'b1 || bus.hist_out !== 10'h000) begin
         mismatched++;
         $display("[TB] FAIL mid_cleared: got v=%b h=%h expected v=1 h=000", bus.hist_valid, bus.hist_out);
      end
      idle();
   endtask

   task automatic test_aliasing();
      drive(1'b0, 32'h0, 1'b1, 32'h0000_2004, 1'b1);
      drive(1'b1, 32'h0000_0004, 1'b0, 32'h0, 1'b0);
      compared++;
      if (bus.hist_valid !== 1'b1 || bus.hist_out !== 10'h001) begin
         mismatched++;
         $display("[TB] FAIL alias_shared: got v=%b h=%h expected v=1 h=001", bus.hist_valid, bus.hist_out);
      end
      drive(1'b1, 32'h0000_1008, 1'b0, 32'h0, 1'b0);
      compared++;
      if (bus.hist_valid !== 1'b1 || bus.hist_out !== 10'h000) begin
         mismatched++;
         $display("[TB] FAIL alias_neighbour: got v=%b h=%h expected v=1 h=000", bus.hist_valid, bus.hist_out);
      end
      idle();
   endtask

   // Scenario sequence; every wait is a fixed number of cycles so the run always ends.
   initial begin
      compared         = 0;
      mismatched       = 0;
      reset            = 1'b1;
      bus.lookup_valid = 1'b0;
      bus.lookup_pc    = 32'h0;
      bus.update_valid = 1'b0;
      bus.update_pc    = 32'h0;
      bus.update_taken = 1'b0;
      test_reset();
      test_init_sweep("boot");
      test_first_lookup();
      test_update_shift();
      test_bypass();
      test_back_to_back();
      test_shift_out();
      test_reset_mid_run();
      test_aliasing();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
